decoder_ctrl: RTL and testbench
===============================

Name: decoder_ctrl

Overview:
- Sequencer for the 1024-bit pattern decoder datapath: program SIPO register, free-running signal SIPO register, and equality comparator.
- Clears both registers and streams a host pattern into the program register with a valid/ready handshake.
- Waits until the signal register holds N fresh bits, then arms. Qualifies comparator hits into match pulses with hold-off and a saturating match counter.

Parameters:
- N, 1024, pattern length in bits; must equal datapath register width.
- CNT_W, 16, match counter width.
- HOLDOFF, 0, cycles of pulse suppression after a reported match (0 = none).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request: clear datapath and begin pattern load.
- disarm  in  1  single-cycle request: stop matching, return to IDLE.
- prgm_valid  in  1  host pattern bit valid.
- prgm_bit  in  1  host pattern bit, first bit shifted first.
- prgm_ready  out  1  controller accepts a pattern bit this cycle.
- sig_in  in  1  serial signal stream.
- eq  in  1  comparator result from datapath.
- dec_clr  out  1  datapath clear, active-high.
- dec_enable  out  1  program-register shift enable.
- dec_prgm  out  1  program-register serial input.
- dec_sig  out  1  signal-register serial input.
- armed  out  1  matching active.
- busy  out  1  in CLEAR or LOAD, or warm-up incomplete.
- match_pulse  out  1  one-cycle registered match indication.
- match_count  out  CNT_W  saturating number of reported matches.

Behaviour:
- Reset (clr low at clk edge):
  - state = IDLE; all counters 0; armed = 0, busy = 0, match_pulse = 0, match_count = 0.
  - dec_clr is forced high combinationally while clr is low.
- Datapath drive:
  - dec_sig = sig_in, combinational pass-through; the signal register shifts every cycle.
  - dec_prgm = prgm_bit.
  - dec_enable = (state == LOAD) & prgm_valid & prgm_ready.
  - prgm_ready = (state == LOAD).
  - dec_clr = ~clr | (state == CLEAR).
- States: IDLE, CLEAR, LOAD, WAIT, ARMED.
  - IDLE: idle. start → CLEAR.
  - CLEAR: exactly 1 cycle; dec_clr high; bit_cnt = 0, fill_cnt = 0, match_count = 0, holdoff counter = 0. → LOAD.
  - LOAD: each cycle with prgm_valid high, one bit is accepted and bit_cnt increments. The cycle accepting bit N-1 transitions: → ARMED if fill_cnt has reached N, else → WAIT. Stalls (prgm_valid low) are unbounded.
  - fill_cnt: increments every cycle after CLEAR, saturates at N. It counts signal-register shifts since the clear.
  - WAIT: → ARMED on the cycle fill_cnt reaches N.
  - ARMED: armed = 1. disarm → IDLE. Pattern is retained; no re-clear.
- busy = state in {CLEAR, LOAD, WAIT}.
- Matching (ARMED only):
  - When eq = 1 and the hold-off counter is 0, match_pulse is asserted on the next cycle (latency 1, width 1).
  - On that same edge, match_count increments (saturates at 2^CNT_W - 1) and the hold-off counter loads HOLDOFF.
  - The hold-off counter decrements to 0, one per cycle. eq is ignored while it is nonzero.
  - eq held high for several cycles with HOLDOFF = 0 gives one pulse per cycle.
- eq is ignored in every state other than ARMED; match_pulse is 0 outside ARMED, except a pulse already registered on the transition edge.
- Simultaneous events and mid-operation requests:
  - start has priority over disarm in every state.
  - start in LOAD, WAIT or ARMED aborts and re-enters CLEAR; partial patterns are discarded.
  - disarm outside ARMED is ignored.
  - clr low mid-load returns to IDLE with all state reset.
- match_count holds its value in IDLE after disarm until the next start.

Test Plan (N = 8, CNT_W = 4 unless stated):
- Reset/idle: hold clr low 3 cycles, then release → dec_clr high during reset, then 0; armed = 0, busy = 0, match_count = 0, prgm_ready = 0.
- Load with stalls: start, then feed 8 bits 10110010 with prgm_valid low on every 3rd cycle → dec_enable high exactly 8 cycles with dec_prgm matching the bits in order; ARMED entered only after fill_cnt = 8; busy falls on the same edge armed rises.
- Match latency and count: armed; drive eq high for 1 cycle at cycle T → match_pulse high at T+1 only; match_count = 1. eq high for 3 consecutive cycles (HOLDOFF = 0) → 3 pulses; count = 4.
- Hold-off (HOLDOFF = 4): eq held high 10 cycles → pulses at offsets 1 and 6 only; count = 2.
- Saturation: produce 20 matches → match_count stops at 15.
- Abort/priority: start mid-LOAD after 5 bits → dec_clr pulses 1 cycle and bit_cnt restarts; a full 8-bit reload is required before arming. start and disarm in the same ARMED cycle → CLEAR taken, match_count = 0.

Source files
------------

// File: rtl/decoder_ctrl.sv
// Control sequencer for the serial pattern decoder: clears the datapath, streams
// the host pattern into the program register, arms after warm-up and qualifies hits.
module decoder_ctrl #(
  parameter int N       = 1024,
  parameter int CNT_W   = 16,
  parameter int HOLDOFF = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             disarm,
  input  logic             prgm_valid,
  input  logic             prgm_bit,
  output logic             prgm_ready,
  input  logic             sig_in,
  input  logic             eq,
  output logic             dec_clr,
  output logic             dec_enable,
  output logic             dec_prgm,
  output logic             dec_sig,
  output logic             armed,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count
);

  localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int FILL_W = $clog2(N + 1);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_ARMED
  } state_t;

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  logic              match_pulse_q, match_pulse_d;
  logic              accept;
  logic              hit;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      fill_cnt_q    <= '0;
      hold_q        <= '0;
      match_count_q <= '0;
      match_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      fill_cnt_q    <= fill_cnt_d;
      hold_q        <= hold_d;
      match_count_q <= match_count_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  assign accept = (state_q == S_LOAD) && prgm_valid;
  assign hit    = (state_q == S_ARMED) && eq && (hold_q == '0);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    fill_cnt_d    = fill_cnt_q;
    hold_d        = hold_q;
    match_count_d = match_count_q;
    match_pulse_d = 1'b0;

    if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    if (hit) begin
      match_pulse_d = 1'b1;
      hold_d        = HOLD_LOAD;
      if (match_count_q != CNT_MAX) begin
        match_count_d = match_count_q + 1'b1;
      end
    end

    // fill_cnt counts signal-register shifts since the datapath clear
    if ((state_q == S_LOAD || state_q == S_WAIT || state_q == S_ARMED) &&
        (fill_cnt_q != FILL_FULL)) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
      end
      S_CLEAR: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (fill_cnt_q == FILL_FULL) ? S_ARMED : S_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (fill_cnt_q == FILL_FULL) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (disarm) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // start wins over everything, including disarm and a coincident hit
    if (start) begin
      state_d       = S_CLEAR;
      bit_cnt_d     = '0;
      fill_cnt_d    = '0;
      hold_d        = '0;
      match_count_d = '0;
      match_pulse_d = 1'b0;
    end
  end

  assign prgm_ready  = (state_q == S_LOAD);
  assign dec_enable  = accept;
  assign dec_clr     = ~clr | (state_q == S_CLEAR);
  assign dec_prgm    = prgm_bit;
  assign dec_sig     = sig_in;
  assign armed       = (state_q == S_ARMED);
  assign busy        = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_WAIT);
  assign match_pulse = match_pulse_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_decoder_ctrl.sv
// Bench for decoder_ctrl: two instances (hold-off 0 and 4) share stimulus and are
// checked every cycle against a phase/count model, plus vector table and directed cases.
module tb_decoder_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr = 1'b0, start = 1'b0, disarm = 1'b0;
  logic prgm_valid = 1'b0, prgm_bit = 1'b0, sig_in = 1'b0, eq = 1'b0;
  logic [1:0] prgm_ready, dec_clr, dec_enable, dec_prgm, dec_sig, armed, busy, match_pulse;
  logic [CW-1:0] match_count [2];

  decoder_ctrl #(.N(N), .CNT_W(CW), .HOLDOFF(0)) u_dut0 (
    .clk(clk), .clr(clr), .start(start), .disarm(disarm),
    .prgm_valid(prgm_valid), .prgm_bit(prgm_bit), .prgm_ready(prgm_ready[0]),
    .sig_in(sig_in), .eq(eq), .dec_clr(dec_clr[0]), .dec_enable(dec_enable[0]),
    .dec_prgm(dec_prgm[0]), .dec_sig(dec_sig[0]), .armed(armed[0]), .busy(busy[0]),
    .match_pulse(match_pulse[0]), .match_count(match_count[0])
  );

  decoder_ctrl #(.N(N), .CNT_W(CW), .HOLDOFF(4)) u_dut4 (
    .clk(clk), .clr(clr), .start(start), .disarm(disarm),
    .prgm_valid(prgm_valid), .prgm_bit(prgm_bit), .prgm_ready(prgm_ready[1]),
    .sig_in(sig_in), .eq(eq), .dec_clr(dec_clr[1]), .dec_enable(dec_enable[1]),
    .dec_prgm(dec_prgm[1]), .dec_sig(dec_sig[1]), .armed(armed[1]), .busy(busy[1]),
    .match_pulse(match_pulse[1]), .match_count(match_count[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  // observed vector: {ready, dec_clr, enable, prgm, sig, armed, busy, pulse, count[3:0]}
  logic [11:0] obs [2];

  // Reference model: phase flags, unbounded shift count, per-instance counters.
  bit m_clearing = 0, m_loading = 0, m_waiting = 0, m_armed = 0;
  int m_bits = 0, m_shifts = 0;
  int m_cnt [2] = '{0, 0};
  int m_hold [2] = '{0, 0};
  bit m_pulse [2] = '{0, 0};

  function automatic int hold_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  function automatic logic [11:0] model_vec(input int k);
    logic [11:0] v;
    v = {m_loading, (~clr) | m_clearing, m_loading & prgm_valid, prgm_bit, sig_in,
         m_armed, m_clearing | m_loading | m_waiting, m_pulse[k], 4'(m_cnt[k])};
    return v;
  endfunction

  task automatic model_step();
    bit fire;
    if (!clr) begin
      m_clearing = 0; m_loading = 0; m_waiting = 0; m_armed = 0;
      m_bits = 0; m_shifts = 0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_hold[k] = 0; m_pulse[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      fire = m_armed && eq && (m_hold[k] == 0) && !start;
      m_pulse[k] = fire;
      if (start) begin
        m_cnt[k] = 0; m_hold[k] = 0;
      end else if (fire) begin
        m_cnt[k] = (m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX;
        m_hold[k] = hold_of(k);
      end else if (m_hold[k] > 0) begin
        m_hold[k] = m_hold[k] - 1;
      end
    end
    if (start) begin
      m_clearing = 1; m_loading = 0; m_waiting = 0; m_armed = 0;
      m_bits = 0; m_shifts = 0;
    end else if (m_clearing) begin
      m_clearing = 0; m_loading = 1;
    end else if (m_loading) begin
      if (prgm_valid) begin
        m_bits = m_bits + 1;
        if (m_bits == N) begin
          m_loading = 0; m_bits = 0;
          if (m_shifts >= N) m_armed = 1;
          else m_waiting = 1;
        end
      end
      m_shifts = m_shifts + 1;
    end else if (m_waiting) begin
      if (m_shifts >= N) begin
        m_waiting = 0; m_armed = 1;
      end
      m_shifts = m_shifts + 1;
    end else if (m_armed) begin
      if (disarm) m_armed = 0;
      m_shifts = m_shifts + 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // one clock: drive inputs, compare both instances at negedge, advance model at posedge
  task automatic cyc(input bit c, input bit s, input bit d, input bit v, input bit b, input bit e);
    clr = c; start = s; disarm = d; prgm_valid = v; prgm_bit = b; eq = e;
    sig_in = 1'($urandom);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      obs[k] = {prgm_ready[k], dec_clr[k], dec_enable[k], dec_prgm[k], dec_sig[k],
                armed[k], busy[k], match_pulse[k], match_count[k]};
      chk($sformatf("model_hold%0d", hold_of(k)), int'(obs[k]), int'(model_vec(k)));
    end
    @(posedge clk);
    model_step();
    #1;
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  // start, CLEAR, eight unstalled bits, one WAIT cycle: armed on the next call
  task automatic arm_fast();
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 1, 1'($urandom), 0);
    idle(1);
  endtask

  typedef struct {
    bit s, d, v, b, e;
    logic [9:0] x;  // {ready, dec_clr, enable, armed, busy, pulse, count[3:0]}
  } vec_t;

  function automatic vec_t mk(input bit s, input bit d, input bit v, input bit b, input bit e,
                              input bit rdy, input bit cl, input bit en, input bit arm,
                              input bit bsy, input bit pls, input int cnt);
    vec_t t;
    t.s = s; t.d = d; t.v = v; t.b = b; t.e = e;
    t.x = {rdy, cl, en, arm, bsy, pls, 4'(cnt)};
    return t;
  endfunction

  vec_t tbl [21];
  int   pmask0, pmask1;

  initial begin
    // load 10110010 with every third cycle stalled, then match latency and count
    tbl[0]  = mk(1,0,0,0,0, 0,0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 0,1,0,0,1,0,0);
    tbl[2]  = mk(0,0,1,1,0, 1,0,1,0,1,0,0);
    tbl[3]  = mk(0,0,1,0,0, 1,0,1,0,1,0,0);
    tbl[4]  = mk(0,0,0,0,1, 1,0,0,0,1,0,0);
    tbl[5]  = mk(0,0,1,1,0, 1,0,1,0,1,0,0);
    tbl[6]  = mk(0,0,1,1,0, 1,0,1,0,1,0,0);
    tbl[7]  = mk(0,1,0,0,0, 1,0,0,0,1,0,0);
    tbl[8]  = mk(0,0,1,0,0, 1,0,1,0,1,0,0);
    tbl[9]  = mk(0,0,1,0,0, 1,0,1,0,1,0,0);
    tbl[10] = mk(0,0,0,0,1, 1,0,0,0,1,0,0);
    tbl[11] = mk(0,0,1,1,0, 1,0,1,0,1,0,0);
    tbl[12] = mk(0,0,1,0,0, 1,0,1,0,1,0,0);
    tbl[13] = mk(0,0,0,0,0, 0,0,0,1,0,0,0);
    tbl[14] = mk(0,0,0,0,1, 0,0,0,1,0,0,0);
    tbl[15] = mk(0,0,0,0,0, 0,0,0,1,0,1,1);
    tbl[16] = mk(0,0,0,0,1, 0,0,0,1,0,0,1);
    tbl[17] = mk(0,0,0,0,1, 0,0,0,1,0,1,2);
    tbl[18] = mk(0,0,0,0,1, 0,0,0,1,0,1,3);
    tbl[19] = mk(0,0,0,0,0, 0,0,0,1,0,1,4);
    tbl[20] = mk(0,0,0,0,0, 0,0,0,1,0,0,4);

    // reset: clr low three cycles, then release
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_dec_clr", int'(obs[0][10]), 1);
    end
    idle(1);
    chk("rst_idle", int'({obs[0][11:10], obs[0][6:0]}), 0);
    $display("reset: dec_clr=%0b armed=%0b busy=%0b count=%0d", obs[0][10], obs[0][6], obs[0][5], obs[0][3:0]);

    for (int i = 0; i < 21; i++) begin
      cyc(1, tbl[i].s, tbl[i].d, tbl[i].v, tbl[i].b, tbl[i].e);
      chk($sformatf("tbl%0d", i), int'({obs[0][11:9], obs[0][6:0]}), int'(tbl[i].x));
      $display("vec %0d: s=%0b d=%0b v=%0b b=%0b e=%0b -> obs=%b", i,
               tbl[i].s, tbl[i].d, tbl[i].v, tbl[i].b, tbl[i].e, obs[0]);
    end

    // disarm returns to IDLE, count held
    cyc(1, 0, 1, 0, 0, 0);
    idle(1);
    chk("disarm_armed", int'(obs[0][6]), 0);
    chk("disarm_count_held", int'(obs[0][3:0]), 4);
    $display("disarm: armed=%0b count=%0d", obs[0][6], obs[0][3:0]);

    // unstalled load finishes before warm-up: one WAIT cycle
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 1, 1'($urandom), 0);
    idle(1);
    chk("wait_state", int'({obs[0][11], obs[0][6:5]}), 3'b001);
    idle(1);
    chk("wait_to_armed", int'({obs[0][11], obs[0][6:5]}), 3'b010);
    $display("wait path: armed=%0b busy=%0b", obs[0][6], obs[0][5]);

    // hold-off: eq high 10 cycles
    pmask0 = 0; pmask1 = 0;
    for (int j = 0; j < 12; j++) begin
      cyc(1, 0, 0, 0, 0, (j < 10));
      pmask0 |= int'(obs[0][4]) << j;
      pmask1 |= int'(obs[1][4]) << j;
    end
    chk("holdoff0_pulses", pmask0, 32'h7FE);
    chk("holdoff4_pulses", pmask1, (1 << 1) | (1 << 6));
    chk("holdoff4_count", int'(obs[1][3:0]), 2);
    chk("holdoff0_count", int'(obs[0][3:0]), 10);
    $display("holdoff: mask0=0x%0h mask4=0x%0h", pmask0, pmask1);

    // saturation: 20 matches
    arm_fast();
    for (int j = 0; j < 21; j++) cyc(1, 0, 0, 0, 0, (j < 20));
    chk("sat_count", int'(obs[0][3:0]), CMAX);
    chk("sat_pulse", int'(obs[0][4]), 1);
    $display("saturation: count=%0d", obs[0][3:0]);

    // abort mid-load after 5 bits; full reload needed
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 1'($urandom), 0);
    cyc(1, 1, 0, 1, 1, 0);
    idle(1);
    chk("abort_dec_clr", int'(obs[0][10]), 1);
    idle(1);
    chk("abort_clr_low", int'({obs[0][11:10]}), 2'b10);
    for (int i = 0; i < N - 1; i++) cyc(1, 0, 0, 1, 1'($urandom), 0);
    idle(1);
    chk("abort_not_armed", int'({obs[0][11], obs[0][6:5]}), 3'b101);
    cyc(1, 0, 0, 1, 0, 0);
    idle(1);
    chk("abort_reload_armed", int'(obs[0][6]), 1);
    $display("abort: armed after full reload=%0b", obs[0][6]);

    // start and disarm together in ARMED
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 1, 1, 0, 0, 0);
    idle(1);
    chk("prio_clear", int'({obs[0][10], obs[0][6:5], obs[0][3:0]}), 7'b1010000);
    $display("priority: dec_clr=%0b armed=%0b count=%0d", obs[0][10], obs[0][6], obs[0][3:0]);

    // clr low mid-load
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1'($urandom), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("midload_rst_clr", int'(obs[0][10]), 1);
    idle(1);
    chk("midload_rst_idle", int'({obs[0][11:10], obs[0][6:0]}), 0);
    $display("mid-load reset: busy=%0b ready=%0b", obs[0][5], obs[0][11]);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 80) != 0, ($urandom % 24) == 0, ($urandom % 16) == 0,
          ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0);
    end
    $display("random: 800 cycles applied");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
